// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the digit counter width function.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for ndig digits; never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple adder built from full_adder cells.
// msb_cin exposes the carry into the top bit for signed overflow detection.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout    = c[DIGIT];
  assign msb_cin = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple digit adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial A+B / A-B engine: DIGIT bits per cycle, NDIG cycles per operation.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_params
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout;
  logic                   dig_msb_cin;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_shift;
  logic                   last;
  logic                   accept;
  logic                   release_res;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_sh[DIGIT-1:0]),
    .b       (b_sh[DIGIT-1:0]),
    .cin     (carry),
    .s       (dig_s),
    .cout    (dig_cout),
    .msb_cin (dig_msb_cin)
  );

  // New digit enters at the MSB end; after NDIG shifts the word is in place.
  assign sum_cat     = {dig_s, sum_sh};
  assign sum_shift   = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last        = (cnt == LAST);
  assign accept      = (state == IDLE) && in_valid;
  assign release_res = (state == DONE) && out_ready;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = RUN;
      RUN:     if (last)        state_next = DONE;
      DONE:    if (release_res) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
      a_sh  <= a;
      b_sh  <= op_sub ? ~b : b;
      carry <= op_sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_shift;
      carry  <= dig_cout;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum  <= sum_shift;
        cout <= dig_cout;
        ovf  <= dig_msb_cin ^ dig_cout;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomised checks of addsub_serial over several WIDTH/DIGIT pairs.
module tb_addsub_serial;

  localparam int NI = 6;
  int wd [NI] = '{8, 16, 16, 32, 32, 8};
  int dg [NI] = '{1, 4, 16, 8, 1, 2};

  logic clk;
  logic rst_n;

  logic [NI-1:0] in_valid_v;
  logic [NI-1:0] sub_v;
  logic [NI-1:0] out_ready_v;
  logic [31:0]   a_v [NI];
  logic [31:0]   b_v [NI];

  wire  [NI-1:0] in_ready_w;
  wire  [NI-1:0] out_valid_w;
  wire  [NI-1:0] cout_w;
  wire  [NI-1:0] ovf_w;
  logic [31:0]   sum_w [NI];

  logic [7:0]  s0;
  logic [15:0] s1;
  logic [15:0] s2;
  logic [31:0] s3;
  logic [31:0] s4;
  logic [7:0]  s5;

  assign sum_w[0] = {24'd0, s0};
  assign sum_w[1] = {16'd0, s1};
  assign sum_w[2] = {16'd0, s2};
  assign sum_w[3] = s3;
  assign sum_w[4] = s4;
  assign sum_w[5] = {24'd0, s5};

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .op_sub(sub_v[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready_v[0]), .sum(s0), .cout(cout_w[0]), .ovf(ovf_w[0]));
  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .op_sub(sub_v[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready_v[1]), .sum(s1), .cout(cout_w[1]), .ovf(ovf_w[1]));
  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .op_sub(sub_v[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready_v[2]), .sum(s2), .cout(cout_w[2]), .ovf(ovf_w[2]));
  addsub_serial #(.WIDTH(32), .DIGIT(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .a(a_v[3]), .b(b_v[3]), .op_sub(sub_v[3]), .out_valid(out_valid_w[3]),
    .out_ready(out_ready_v[3]), .sum(s3), .cout(cout_w[3]), .ovf(ovf_w[3]));
  addsub_serial #(.WIDTH(32), .DIGIT(1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_w[4]),
    .a(a_v[4]), .b(b_v[4]), .op_sub(sub_v[4]), .out_valid(out_valid_w[4]),
    .out_ready(out_ready_v[4]), .sum(s4), .cout(cout_w[4]), .ovf(ovf_w[4]));
  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[5]), .in_ready(in_ready_w[5]),
    .a(a_v[5][7:0]), .b(b_v[5][7:0]), .op_sub(sub_v[5]), .out_valid(out_valid_w[5]),
    .out_ready(out_ready_v[5]), .sum(s5), .cout(cout_w[5]), .ovf(ovf_w[5]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Behavioural reference: full-width arithmetic, then extract flags.
  function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic sub);
    logic [63:0] bb, full, s;
    logic        c, o, sa, sb, ss;
    bb   = sub ? {32'd0, ~bv & mask_of(w)} : {32'd0, bv};
    full = {32'd0, av} + bb + {63'd0, sub};
    s    = full & {32'd0, mask_of(w)};
    c    = full[w];
    sa   = av[w-1];
    sb   = bb[w-1];
    ss   = s[w-1];
    o    = (sa == sb) && (ss != sa);
    return {o, c, s[31:0]};
  endfunction

  // Driver: accept, measure latency, check result, optionally stall in DONE, release.
  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input int stall, input string nm);
    int n;
    int lat;
    n = 0;
    while (!in_ready_w[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " in_ready_before"}, {31'd0, in_ready_w[k]}, 32'd1);
    a_v[k] = av; b_v[k] = bv; sub_v[k] = sub; in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom; sub_v[k] = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid_w[k] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({nm, " latency"}, lat, wd[k] / dg[k]);
    check({nm, " sum"}, sum_w[k], es);
    check({nm, " cout"}, {31'd0, cout_w[k]}, {31'd0, ec});
    check({nm, " ovf"}, {31'd0, ovf_w[k]}, {31'd0, eo});
    for (int i = 0; i < stall; i++) begin
      in_valid_v[k] = 1'($urandom_range(0, 1));
      a_v[k] = $urandom; b_v[k] = $urandom;
      @(posedge clk); #1;
      check({nm, " stall_sum"}, sum_w[k], es);
      check({nm, " stall_flags"}, {28'd0, cout_w[k], ovf_w[k], in_ready_w[k], out_valid_w[k]},
            {28'd0, ec, eo, 1'b0, 1'b1});
    end
    in_valid_v[k] = 1'b0;
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    check({nm, " after_release"}, {30'd0, in_ready_w[k], out_valid_w[k]}, 32'd2);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] ra, rb;
    logic        rs;
    logic        stale;

    tbl[0]  = '{0, 32'd200, 32'd100, 1'b0, 32'd44, 1'b1, 1'b0};
    tbl[1]  = '{0, 32'd100, 32'd100, 1'b0, 32'd200, 1'b0, 1'b1};
    tbl[2]  = '{0, 32'd5, 32'd7, 1'b1, 32'hFE, 1'b0, 1'b0};
    tbl[3]  = '{0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1};
    tbl[4]  = '{1, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0};
    tbl[5]  = '{2, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1};
    tbl[6]  = '{3, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[7]  = '{3, 32'h0, 32'h1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[8]  = '{4, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[9]  = '{5, 32'h7F, 32'hFF, 1'b1, 32'h80, 1'b0, 1'b1};
    tbl[10] = '{5, 32'h55, 32'hAA, 1'b0, 32'hFF, 1'b0, 1'b0};

    in_valid_v = '0; sub_v = '0; out_ready_v = '0;
    for (int i = 0; i < NI; i++) begin
      a_v[i] = '0; b_v[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_sum", sum_w[i], 32'd0);
      check("reset_ctrl", {28'd0, in_ready_w[i], out_valid_w[i], cout_w[i], ovf_w[i]}, 32'h8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 11; i++)
      run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].o, 0,
             $sformatf("vec%0d", i));

    // Backpressure with input toggling, then back-to-back operations
    run_op(0, 32'd200, 32'd100, 1'b0, 32'd44, 1'b1, 1'b0, 5, "bp");
    run_op(0, 32'd5, 32'd7, 1'b1, 32'hFE, 1'b0, 1'b0, 0, "b2b_a");
    run_op(0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 0, "b2b_b");

    // Reset during digit 3 of 8
    a_v[0] = 32'd100; b_v[0] = 32'd100; sub_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {30'd0, in_ready_w[0], out_valid_w[0]}, 32'd2);
    check("midrun_reset_sum", sum_w[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) stale = 1'b1;
    end
    check("no_stale_result", {31'd0, stale}, 32'd0);
    run_op(0, 32'd100, 32'd100, 1'b0, 32'd200, 1'b0, 1'b1, 0, "post_reset");

    // Random regression against the reference model
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 12; j++) begin
        ra = $urandom & mask_of(wd[k]);
        rb = $urandom & mask_of(wd[k]);
        rs = 1'($urandom_range(0, 1));
        m  = model(wd[k], ra, rb, rs);
        run_op(k, ra, rb, rs, m[31:0], m[32], m[33], $urandom_range(0, 3),
               $sformatf("rnd%0d_%0d", k, j));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial binary adder/subtractor with a valid/ready handshake. It computes A+B or A−B on WIDTH-bit operands DIGIT bits per clock, trading latency for area relative to a full-width ripple adder. It sits beside the binary arithmetic blocks as the reference binary engine for large-width and area-constrained comparisons against stochastic results. It reports carry-out and signed overflow.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of DIGIT, ≥ 2.
- DIGIT, 1: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands and op_sub are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (subtract: 1 = no borrow, 0 = borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- NDIG = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: load A register ← a, B register ← (op_sub ? ~b : b), carry register ← op_sub, digit counter ← 0; go RUN.
- RUN: each cycle add the low DIGIT bits of A and B registers plus the carry register; shift the DIGIT result bits into the sum register from the MSB end; shift A and B registers right by DIGIT; carry register ← digit carry-out; counter +1.
- On the final digit (counter = NDIG−1): cout ← digit carry-out; ovf ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1; go DONE.
- DONE: out_valid=1; sum/cout/ovf held stable until out_valid && out_ready, then go IDLE.
- in_ready is 0 in RUN and DONE; inputs are ignored there. No accept in the same cycle as result release.
- a, b, op_sub are sampled only at the accept edge; later changes have no effect.
- DIGIT = WIDTH: RUN lasts one cycle.

## Timing
- Reset (rst_n low, any state, including mid-RUN or DONE): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, internal registers 0. In-flight operation is discarded, no result produced.
- Accept at edge t0 → out_valid rises after edge t0+NDIG (NDIG RUN cycles).
- Result release at edge t1 (out_valid && out_ready) → in_ready=1 in the following cycle; next accept no earlier than edge t1+1.
- Throughput: one operation per NDIG+2 cycles with out_ready held high.
- sum, cout, ovf are registered; they change only on the final RUN edge and reset. Their values while out_valid=0 are don't-care for checking.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Shared package addsub_pkg: state enum (IDLE, RUN, DONE) and a function for counter width, $clog2(NDIG) with minimum 1.
- One sub-module addsub_digit: DIGIT-bit combinational ripple adder with a, b, cin inputs and s, cout, and msb_cin (carry into the top bit) outputs, built from the team's existing full_adder cell. msb_cin is used for ovf on the final digit.
- Top: FSM, counter, operand/sum shift registers, handshake logic.
- Elaboration-time check: WIDTH % DIGIT == 0, else $error.

## Test plan
- WIDTH=8, DIGIT=1, add 200+100 → sum=44, cout=1, ovf=0; out_valid exactly 8 cycles after accept.
- WIDTH=8, DIGIT=1, add 100+100 → sum=200, cout=0, ovf=1. Subtract 5−7 → sum=0xFE, cout=0, ovf=0. Subtract 0x80−1 → sum=0x7F, cout=1, ovf=1.
- WIDTH=16, DIGIT=4, add 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0, latency 4. DIGIT=16, add 0x7FFF+1 → sum=0x8000, ovf=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle a/b/in_valid → sum/cout/ovf stable, in_ready=0. Release → in_ready=1 the next cycle, and back-to-back operations give correct results.
- Reset asserted mid-RUN (digit 3 of 8) → immediately in_ready=1, out_valid=0, sum=0. No stale result afterward, and the next operation is correct.
- Random regression, WIDTH ∈ {8,16,32}, DIGIT ∈ divisors: compare sum/cout/ovf against a behavioural model with random out_ready stalls.
